// File: rtl/audio_pkg.sv
// Shared audio-chain types and constants.
// Used by the delay effect and the I2S transmitter.
package audio_pkg;
    localparam int AUDIO_DATA_WIDTH = 16;
    typedef logic signed [AUDIO_DATA_WIDTH-1:0] sample_t;

    localparam int I2S_SLOT_WIDTH = 32;
    localparam int I2S_BCLK_HALF  = 16;

    typedef enum logic {
        TX_IDLE,
        TX_RUN
    } tx_state_t;
endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK divider for the I2S transmitter.
// Produces bclk and a strobe marking the cycle of its 1->0 toggle.
module i2s_clk_gen #(
    parameter int BCLK_HALF = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic bclk,
    output logic fall
);
    localparam int DIVW = $clog2(BCLK_HALF);

    logic [DIVW-1:0] div_cnt;
    logic            wrap;

    assign wrap = enable && (div_cnt == DIVW'(BCLK_HALF - 1));
    assign fall = wrap && bclk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/i2s_tx.sv
// Mono-to-stereo Philips I2S transmitter, final stage of the audio chain.
// Emits a per-frame strobe used upstream as the sample tick.
module i2s_tx
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = AUDIO_DATA_WIDTH,
    parameter int SLOT_WIDTH = I2S_SLOT_WIDTH,
    parameter int BCLK_HALF  = I2S_BCLK_HALF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] audio_in,
    output logic                         i2s_bclk,
    output logic                         i2s_lrclk,
    output logic                         i2s_sdata,
    output logic                         frame_start,
    output logic                         underrun,
    output logic                         overrun
);
    localparam int FRAME = 2 * SLOT_WIDTH;
    localparam int BW    = $clog2(FRAME);

    tx_state_t             state;
    logic [BW-1:0]         bit_cnt;
    logic [BW-1:0]         k;
    logic                  right;
    logic [DATA_WIDTH-1:0] hold;
    logic                  full;
    logic [DATA_WIDTH-1:0] frame_s;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] next_s;
    logic                  run;
    logic                  fall;
    logic                  boundary;
    logic                  start;
    logic                  stop;
    logic                  clear;

    assign run = enable || (state == TX_RUN);

    i2s_clk_gen #(
        .BCLK_HALF(BCLK_HALF)
    ) u_clk_gen (
        .clk   (clk),
        .reset (reset),
        .enable(run),
        .bclk  (i2s_bclk),
        .fall  (fall)
    );

    assign boundary = fall && (state == TX_RUN) && (bit_cnt == '0);
    assign start    = boundary && enable;
    assign stop     = boundary && !enable;
    assign clear    = start && full;

    always_comb begin
        right  = bit_cnt >= BW'(SLOT_WIDTH);
        k      = right ? bit_cnt - BW'(SLOT_WIDTH) : bit_cnt;
        next_s = (bit_cnt == '0 && full) ? hold : frame_s;
    end

    // A new sample landing on the boundary cycle replaces the one consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold    <= '0;
            full    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= sample_valid && full && !clear;
            if (sample_valid) begin
                hold <= audio_in;
                full <= 1'b1;
            end else if (clear) begin
                full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= TX_IDLE;
            bit_cnt     <= '0;
            frame_s     <= '0;
            shreg       <= '0;
            i2s_lrclk   <= 1'b0;
            i2s_sdata   <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            unique case (state)
                TX_IDLE: begin
                    bit_cnt   <= '0;
                    i2s_lrclk <= 1'b0;
                    i2s_sdata <= 1'b0;
                    if (enable) state <= TX_RUN;
                end
                TX_RUN: begin
                    if (stop) begin
                        state     <= TX_IDLE;
                        bit_cnt   <= '0;
                        i2s_lrclk <= 1'b0;
                        i2s_sdata <= 1'b0;
                    end else if (fall) begin
                        bit_cnt   <= (bit_cnt == BW'(FRAME - 1))
                                     ? '0 : bit_cnt + 1'b1;
                        i2s_lrclk <= right;
                        // k=0 is the I2S one-bit delay slot
                        if (k == '0) begin
                            shreg     <= next_s;
                            i2s_sdata <= 1'b0;
                        end else if (k <= BW'(DATA_WIDTH)) begin
                            i2s_sdata <= shreg[DATA_WIDTH-1];
                            shreg     <= shreg << 1;
                        end else begin
                            i2s_sdata <= 1'b0;
                        end
                        if (bit_cnt == '0) begin
                            frame_start <= 1'b1;
                            underrun    <= !full;
                            if (full) frame_s <= hold;
                        end
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end
endmodule
